// File: rtl/uart_rx_packer.sv
// uart_rx_packer: 8N1 UART receiver that packs bytes LSB-first into
// WIDTH-bit words for a downstream FIFO, with framing flag and idle timeout.
module uart_rx_packer #(
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  output logic [WIDTH-1:0] data_out,
  output logic             write,
  output logic             frame_err,
  output logic             busy
);

  localparam int NB   = WIDTH / 8;
  localparam int BW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TLIM = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW   = (TLIM > 1) ? $clog2(TLIM + 1) : 1;
  localparam int TCMP = (TLIM > 0) ? TLIM - 1 : 0;
  localparam bit TEN  = (TIMEOUT_BITS > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_s1;
  logic             r_s2;
  logic             w_rx;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [WIDTH-1:0] r_pack;
  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] r_dout;
  logic [BW-1:0]    r_idx;
  logic [TW-1:0]    r_tcnt;
  logic             r_write;
  logic             r_ferr;
  logic             w_tick;
  logic             w_shift;
  logic             w_accept;
  logic             w_ferr;
  logic             w_done;
  logic             w_tout;
  logic             w_busy;

  assign w_rx      = r_s2;
  assign data_out  = r_dout;
  assign write     = r_write;
  assign frame_err = r_ferr;
  assign busy      = w_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_rx) w_next = S_START;
      end
      S_START: begin
        if (w_tick) w_next = w_rx ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_tick && r_bit == 3'd7) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_tick) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_tick = 1'b0;
    case (r_state)
      S_START: w_tick = (r_cnt == CW'(HALF - 1));
      S_DATA:  w_tick = (r_cnt == CW'(CLKS_PER_BIT - 1));
      S_STOP:  w_tick = (r_cnt == CW'(CLKS_PER_BIT - 1));
      default: w_tick = 1'b0;
    endcase
    w_busy   = (r_state != S_IDLE);
    w_shift  = (r_state == S_DATA) && w_tick;
    w_accept = (r_state == S_STOP) && w_tick && w_rx;
    w_ferr   = (r_state == S_STOP) && w_tick && !w_rx;
    w_done   = w_accept && (r_idx == BW'(NB - 1));
    w_tout   = TEN && (r_state == S_IDLE) && (r_idx != '0)
               && (r_tcnt == TW'(TCMP));
  end

  // Current pack register with the just-received byte dropped into its lane
  always_comb begin
    w_word = r_pack;
    for (int i = 0; i < NB; i++) begin
      if (r_idx == BW'(i)) w_word[8*i +: 8] = r_shift;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_pack  <= '0;
      r_dout  <= '0;
      r_idx   <= '0;
      r_tcnt  <= '0;
      r_write <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_s1 <= rx;
      r_s2 <= r_s1;
      if (w_tick || r_state == S_IDLE) r_cnt <= '0;
      else r_cnt <= r_cnt + CW'(1);
      if (r_state != S_DATA) r_bit <= '0;
      else if (w_shift) r_bit <= r_bit + 3'd1;
      if (w_shift) r_shift <= {w_rx, r_shift[7:1]};
      r_write <= w_done;
      r_ferr  <= w_ferr;
      if (w_done) r_dout <= w_word;
      if (w_ferr || w_done || w_tout) begin
        r_idx  <= '0;
        r_pack <= '0;
      end else if (w_accept) begin
        r_idx  <= r_idx + BW'(1);
        r_pack <= w_word;
      end
      // Idle timer only runs while a partial word sits waiting in IDLE
      if (r_state == S_IDLE && w_next == S_IDLE && r_idx != '0 && !w_tout)
        r_tcnt <= r_tcnt + TW'(1);
      else
        r_tcnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_packer.sv
// tb_uart_rx_packer: directed scoreboard bench for uart_rx_packer
// (CLKS_PER_BIT=16, WIDTH=32, TIMEOUT_BITS=20).
module tb_uart_rx_packer;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic [31:0] data_out;
  logic        write;
  logic        frame_err;
  logic        busy;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int n_fe = 0;
  int n_both = 0;
  int fe0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          obs_c[$];
  logic [31:0] m_word = '0;
  int          m_idx = 0;

  always #5 clk = ~clk;

  uart_rx_packer #(
    .WIDTH(32),
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .data_out(data_out),
    .write(write),
    .frame_err(frame_err),
    .busy(busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write) begin
      obs_q.push_back(data_out);
      obs_c.push_back(cyc);
    end
    if (frame_err) n_fe++;
    if (write && frame_err) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_word = '0;
    m_idx  = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_word[8*m_idx +: 8] = b;
    m_idx++;
    if (m_idx == 4) begin
      exp_q.push_back(m_word);
      model_clear();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    if (stop) model_byte(b);
    else model_clear();
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 40 * CPB) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_word"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
    obs_c.delete();
  endtask

  initial begin
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", data_out, 32'h0);
    chk("rst_write", {31'b0, write}, 32'h0);
    chk("rst_ferr", {31'b0, frame_err}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    fe0 = n_fe;
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    idle_bits(2);
    drain("t1_basic");
    chk("t1_ferr", n_fe - fe0, 32'd0);

    fe0 = n_fe;
    send_byte(8'hA0, 1'b1);
    send_byte(8'hA1, 1'b1);
    idle_bits(2);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("t2_busy_start", {31'b0, busy}, 32'h1);
    idle_bits(2);
    chk("t2_busy_idle", {31'b0, busy}, 32'h0);
    chk("t2_nowrite", obs_q.size(), 32'd0);
    send_byte(8'hA2, 1'b1);
    send_byte(8'hA3, 1'b1);
    idle_bits(2);
    drain("t2_glitch");
    chk("t2_ferr", n_fe - fe0, 32'd0);

    fe0 = n_fe;
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b0);
    idle_bits(2);
    chk("t3_ferr_pulse", n_fe - fe0, 32'd1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    idle_bits(2);
    drain("t3_frame");
    chk("t3_ferr_total", n_fe - fe0, 32'd1);

    fe0 = n_fe;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle_bits(25);
    chk("t4_idle_nowrite", obs_q.size(), 32'd0);
    model_clear();
    send_byte(8'hA1, 1'b1);
    send_byte(8'hB2, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hD4, 1'b1);
    idle_bits(2);
    drain("t4_timeout");
    chk("t4_ferr", n_fe - fe0, 32'd0);

    for (int b = 0; b < 8; b++) send_byte(8'(b), 1'b1);
    idle_bits(2);
    chk("t5_spacing",
        (obs_c.size() >= 2) ? obs_c[1] - obs_c[0] : 0, 32'd640);
    drain("t5_b2b");

    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      repeat (CPB) @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_data", data_out, 32'h0);
    chk("t6_rst_write", {31'b0, write}, 32'h0);
    chk("t6_rst_ferr", {31'b0, frame_err}, 32'h0);
    chk("t6_rst_busy", {31'b0, busy}, 32'h0);
    rx = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    chk("t6_rst_hold", {data_out[31:1], data_out[0] | busy}, 32'h0);
    reset = 1'b0;
    idle_bits(2);
    chk("t6_nowrite", obs_q.size(), 32'd0);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    idle_bits(2);
    drain("t6_reset");

    chk("never_write_and_ferr", n_both, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
